// File: rtl/effect_echo_pkg.sv
// Shared types and helpers for the SRAM-backed feedback echo.
package effect_echo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_REQ   = 3'd1,
        ST_RD_LATCH = 3'd2,
        ST_CALC     = 3'd3,
        ST_WRITE    = 3'd4
    } echo_state_t;

    localparam int FB_SHIFT = 3;

    function automatic int level_to_delay(input logic [2:0] level, input int step, input int depth);
        int d;
        d = (int'(level) + 1) * step;
        return (d > depth - 1) ? depth - 1 : d;
    endfunction

    function automatic longint sat(input longint value, input int width);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (width - 1)) - longint'(1);
        lo = -(longint'(1) <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/echo_addr_gen.sv
// Circular-buffer pointer generator: write pointer with wrap, read pointer trailing by the delay.
module echo_addr_gen #(
    parameter int ADDR_W    = 20,
    parameter int MAX_DEPTH = 32000,
    parameter int BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_advance,
    input  logic [ADDR_W-1:0] i_delay,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [ADDR_W-1:0] o_rd_addr
);

    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(MAX_DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(MAX_DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
        end else if (i_advance) begin
            wr_ptr <= (wr_ptr == LAST_C) ? '0 : wr_ptr + ADDR_W'(1);
        end
    end

    // The modular sum may wrap ADDR_W bits in the middle, but the final value is < MAX_DEPTH.
    always_comb begin
        if (wr_ptr >= i_delay) begin
            rd_ptr = wr_ptr - i_delay;
        end else begin
            rd_ptr = wr_ptr + DEPTH_C - i_delay;
        end
    end

    assign o_wr_addr = BASE_C + wr_ptr;
    assign o_rd_addr = BASE_C + rd_ptr;

endmodule

// File: rtl/effect_echo_fb.sv
// Feedback echo: reads the sample D slots back, writes input plus scaled echo, outputs dry/wet mix.
//
// state       | meaning
// ST_IDLE     | bus released, waiting for i_valid
// ST_RD_REQ   | read address driven (first read cycle)
// ST_RD_LATCH | read address driven, SRAM data captured at end
// ST_CALC     | feedback write value and output mix registered
// ST_WRITE    | feedback value written at wr_ptr, pointer advances
module effect_echo_fb
    import effect_echo_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 20,
    parameter int MAX_DEPTH  = 32000,
    parameter int DELAY_STEP = 4000,
    parameter int BASE_ADDR  = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_enable,
    input  logic [2:0]        i_level,
    input  logic [2:0]        i_feedback,
    input  logic [2:0]        i_mix,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_sram_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we_n,
    output logic [DATA_W-1:0] o_sram_wdata,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int PW        = DATA_W + 4;
    localparam int MIX_SHIFT = 3;

    echo_state_t state;

    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] d_q;
    logic signed [DATA_W-1:0] fbv_q;
    logic signed [DATA_W-1:0] y_q;
    logic [2:0]               fb_q;
    logic [2:0]               mix_q;
    logic                     en_q;
    logic [ADDR_W-1:0]        delay_q;

    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] d_ext;
    logic signed [PW-1:0] fb_ext;
    logic signed [PW-1:0] mix_ext;
    logic signed [PW-1:0] dry_ext;
    logic signed [PW-1:0] fb_term;
    logic signed [PW-1:0] fb_sum;
    logic signed [PW-1:0] wet_sum;
    logic signed [DATA_W-1:0] fbv_next;
    logic signed [DATA_W-1:0] y_next;

    echo_addr_gen #(
        .ADDR_W    (ADDR_W),
        .MAX_DEPTH (MAX_DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) u_addr_gen (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_advance (state == ST_WRITE),
        .i_delay   (delay_q),
        .o_wr_addr (wr_addr),
        .o_rd_addr (rd_addr)
    );

    // Products stay within PW bits: |x*8| and |d*7| both fit below 2^(DATA_W+3).
    always_comb begin
        x_ext    = {{(PW-DATA_W){x_q[DATA_W-1]}}, x_q};
        d_ext    = {{(PW-DATA_W){d_q[DATA_W-1]}}, d_q};
        fb_ext   = {{(PW-3){1'b0}}, fb_q};
        mix_ext  = {{(PW-3){1'b0}}, mix_q};
        dry_ext  = PW'(8) - mix_ext;
        fb_term  = (d_ext * fb_ext) >>> FB_SHIFT;
        fb_sum   = x_ext + fb_term;
        wet_sum  = (x_ext * dry_ext + d_ext * mix_ext) >>> MIX_SHIFT;
        fbv_next = x_q;
        y_next   = x_q;
        if (en_q) begin
            fbv_next = DATA_W'(sat(longint'(fb_sum), DATA_W));
            y_next   = wet_sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            x_q       <= '0;
            d_q       <= '0;
            fbv_q     <= '0;
            y_q       <= '0;
            fb_q      <= '0;
            mix_q     <= '0;
            en_q      <= 1'b0;
            delay_q   <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_valid && (state != ST_IDLE)) begin
                o_overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        x_q     <= i_data;
                        fb_q    <= i_feedback;
                        mix_q   <= i_mix;
                        en_q    <= i_enable;
                        delay_q <= ADDR_W'(level_to_delay(i_level, DELAY_STEP, MAX_DEPTH));
                        state   <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    state <= ST_RD_LATCH;
                end
                ST_RD_LATCH: begin
                    d_q   <= i_sram_rdata;
                    state <= ST_CALC;
                end
                ST_CALC: begin
                    fbv_q <= fbv_next;
                    y_q   <= y_next;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    o_valid <= 1'b1;
                    o_data  <= y_q;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus is decoded from state so an async reset releases the write strobe at once.
    always_comb begin
        o_sram_addr  = '0;
        o_sram_we_n  = 1'b1;
        o_sram_wdata = '0;
        case (state)
            ST_RD_REQ, ST_RD_LATCH: begin
                o_sram_addr = rd_addr;
            end
            ST_WRITE: begin
                o_sram_addr  = wr_addr;
                o_sram_we_n  = 1'b0;
                o_sram_wdata = fbv_q;
            end
            default: begin
            end
        endcase
    end

    assign o_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_effect_echo_fb.sv
// Bench for effect_echo_fb: vector table plus hand-written overrun, reset and wrap sequences.
module tb_effect_echo_fb;

    logic i_clk;
    logic rst_n;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // main instance: D = (level+1)*4, 32000-slot buffer at address 0
    logic        va, ena;
    logic [2:0]  lva, fba, mixa;
    logic [15:0] da, rda, wda, oda;
    logic [19:0] addra;
    logic        wena, ova, busya, ovra;

    effect_echo_fb #(
        .DATA_W(16), .ADDR_W(20), .MAX_DEPTH(32000), .DELAY_STEP(4), .BASE_ADDR(0)
    ) u_dut (
        .i_clk(i_clk), .i_rst_n(rst_n), .i_valid(va), .i_enable(ena), .i_level(lva),
        .i_feedback(fba), .i_mix(mixa), .i_data(da), .i_sram_rdata(rda),
        .o_sram_addr(addra), .o_sram_we_n(wena), .o_sram_wdata(wda), .o_data(oda),
        .o_valid(ova), .o_busy(busya), .o_overrun(ovra)
    );

    // small instance for pointer wrap: 10 slots based at address 100, D = (level+1)*3
    logic        vb, enb;
    logic [2:0]  lvb, fbb, mixb;
    logic [15:0] db, rdb, wdb, odb;
    logic [7:0]  addrb;
    logic        wenb, ovb, busyb, ovrb;

    effect_echo_fb #(
        .DATA_W(16), .ADDR_W(8), .MAX_DEPTH(10), .DELAY_STEP(3), .BASE_ADDR(100)
    ) u_wrap (
        .i_clk(i_clk), .i_rst_n(rst_n), .i_valid(vb), .i_enable(enb), .i_level(lvb),
        .i_feedback(fbb), .i_mix(mixb), .i_data(db), .i_sram_rdata(rdb),
        .o_sram_addr(addrb), .o_sram_we_n(wenb), .o_sram_wdata(wdb), .o_data(odb),
        .o_valid(ovb), .o_busy(busyb), .o_overrun(ovrb)
    );

    logic [15:0] mem_a [0:32767];
    logic [15:0] mem_b [0:255];

    assign rda = mem_a[addra[14:0]];
    assign rdb = mem_b[addrb];

    always @(posedge i_clk) begin
        if (!wena) mem_a[addra[14:0]] = wda;
        if (!wenb) mem_b[addrb] = wdb;
    end

    typedef struct {
        logic en;
        int   lvl;
        int   fb;
        int   mix;
        int   x;
        logic pre_en;
        int   pre;
        int   exp_w;
        int   exp_y;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int wr_a  = 0;
    int wr_b  = 0;
    int q_y[$];

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rd_of(input int wr, input int lvl, input int step, input int depth);
        int d;
        d = (lvl + 1) * step;
        if (d > depth - 1) d = depth - 1;
        return (wr >= d) ? wr - d : wr + depth - d;
    endfunction

    function automatic vec_t mk(input logic en, input int lvl, input int fb, input int mix, input int x,
                                input logic pre_en, input int pre, input int exp_w, input int exp_y);
        vec_t v;
        v.en = en; v.lvl = lvl; v.fb = fb; v.mix = mix; v.x = x;
        v.pre_en = pre_en; v.pre = pre; v.exp_w = exp_w; v.exp_y = exp_y;
        return v;
    endfunction

    // Entered in the low phase of cycle 0; returns in the low phase of cycle 5.
    task automatic send_a(input vec_t v);
        int rd;
        rd = rd_of(wr_a, v.lvl, 4, 32000);
        if (v.pre_en) mem_a[rd] = 16'(v.pre);
        va = 1'b1; ena = v.en; lva = 3'(v.lvl); fba = 3'(v.fb); mixa = 3'(v.mix); da = 16'(v.x);
        q_y.push_back(v.exp_y);
        @(negedge i_clk);
        va = 1'b0;
        da = 16'($urandom); ena = 1'($urandom); lva = 3'($urandom); fba = 3'($urandom); mixa = 3'($urandom);
        chk("busy_c1", busya, 1);
        chk("rd_addr_c1", addra, rd);
        chk("we_n_c1", wena, 1);
        @(negedge i_clk);
        chk("rd_addr_c2", addra, rd);
        chk("we_n_c2", wena, 1);
        @(negedge i_clk);
        chk("addr_calc", addra, 0);
        chk("we_n_calc", wena, 1);
        chk("wdata_calc", wda, 0);
        @(negedge i_clk);
        chk("wr_addr", addra, wr_a);
        chk("we_n_wr", wena, 0);
        chk("wdata", $signed(wda), v.exp_w);
        @(negedge i_clk);
        chk("valid_c5", ova, 1);
        chk("busy_c5", busya, 0);
        wr_a = (wr_a + 1) % 32000;
    endtask

    task automatic send_b(input int lvl, input int x);
        int rd;
        rd = rd_of(wr_b, lvl, 3, 10);
        vb = 1'b1; lvb = 3'(lvl); db = 16'(x);
        @(negedge i_clk);
        vb = 1'b0;
        chk("b_rd_addr", addrb, rd + 100);
        chk("b_we_n_rd", wenb, 1);
        @(negedge i_clk);
        @(negedge i_clk);
        @(negedge i_clk);
        chk("b_wr_addr", addrb, wr_b + 100);
        chk("b_we_n_wr", wenb, 0);
        chk("b_wdata", $signed(wdb), x);
        @(negedge i_clk);
        chk("b_valid", ovb, 1);
        chk("b_data", $signed(odb), x);
        wr_b = (wr_b + 1) % 10;
    endtask

    // Output scoreboard: every o_valid must match the oldest pending expectation.
    initial begin
        forever begin
            @(negedge i_clk);
            if (ova === 1'b1) begin
                if (q_y.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_o_valid: o_data=%0d, expected no output", $signed(oda));
                end else begin
                    int e;
                    e = q_y.pop_front();
                    chk("o_data", $signed(oda), e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench still running at %0t, expected to finish", $time);
        $fatal(1);
    end

    initial begin
        vec_t tbl[$];
        rst_n = 1'b0;
        va = 1'b0; ena = 1'b0; lva = '0; fba = '0; mixa = '0; da = '0;
        vb = 1'b0; enb = 1'b0; lvb = '0; fbb = '0; mixb = '0; db = '0;
        for (int i = 0; i < 32768; i++) mem_a[i] = '0;
        for (int i = 0; i < 256; i++) mem_b[i] = '0;

        repeat (3) @(negedge i_clk);
        chk("rst_o_data", oda, 0);
        chk("rst_o_valid", ova, 0);
        chk("rst_o_busy", busya, 0);
        chk("rst_o_overrun", ovra, 0);
        chk("rst_we_n", wena, 1);
        chk("rst_addr", addra, 0);
        chk("rst_wdata", wda, 0);
        rst_n = 1'b1;
        @(negedge i_clk);

        //               en  lvl fb mix  x       pre  val     w       y
        tbl.push_back(mk(1,  0,  4, 4,  16000,  0,   0,      16000,  8000));
        tbl.push_back(mk(1,  0,  4, 4,  0,      0,   0,      0,      0));
        tbl.push_back(mk(1,  0,  4, 4,  0,      0,   0,      0,      0));
        tbl.push_back(mk(1,  0,  4, 4,  0,      0,   0,      0,      0));
        tbl.push_back(mk(1,  0,  4, 4,  0,      0,   0,      8000,   8000));
        tbl.push_back(mk(1,  0,  4, 4,  0,      0,   0,      0,      0));
        tbl.push_back(mk(1,  0,  4, 4,  0,      0,   0,      0,      0));
        tbl.push_back(mk(1,  0,  4, 4,  0,      0,   0,      0,      0));
        tbl.push_back(mk(1,  0,  4, 4,  0,      0,   0,      4000,   4000));
        tbl.push_back(mk(0,  0,  7, 7,  -1234,  0,   0,      -1234,  -1234));
        tbl.push_back(mk(1,  0,  0, 7,  500,    0,   0,      500,    62));
        tbl.push_back(mk(1,  0,  0, 0,  -7,     0,   0,      -7,     -7));
        tbl.push_back(mk(1,  0,  0, 1,  -3,     0,   0,      -3,     497));
        tbl.push_back(mk(1,  0,  1, 4,  1,      0,   0,      -154,   -617));
        tbl.push_back(mk(1,  1,  4, 4,  100,    0,   0,      100,    50));
        tbl.push_back(mk(1,  3,  4, 2,  200,    0,   0,      200,    150));
        tbl.push_back(mk(1,  7,  4, 0,  -8,     0,   0,      -8,     -8));
        tbl.push_back(mk(1,  0,  7, 3,  32767,  1,   32767,  32767,  32767));
        tbl.push_back(mk(1,  0,  7, 3,  -32768, 1,   -32768, -32768, -32768));
        tbl.push_back(mk(1,  0,  7, 7,  -100,   1,   800,    600,    687));
        for (int i = 0; i < tbl.size(); i++) send_a(tbl[i]);
        chk("no_overrun_back_to_back", ovra, 0);

        for (int i = 0; i < 6; i++) begin
            int x;
            x = int'($urandom_range(0, 65535)) - 32768;
            send_a(mk(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), x, 0, 0, x, x));
        end

        for (int i = 0; i < 12; i++) send_b(0, i * 111 - 500);
        send_b(7, 4321);

        // overrun: second strobe lands in cycle 2 and must be dropped
        va = 1'b1; ena = 1'b1; lva = 3'd0; fba = 3'd0; mixa = 3'd0; da = 16'd1000;
        q_y.push_back(1000);
        @(negedge i_clk);
        va = 1'b0;
        @(negedge i_clk);
        chk("overrun_before", ovra, 0);
        va = 1'b1; da = 16'd5555;
        @(negedge i_clk);
        va = 1'b0;
        chk("overrun_c3", ovra, 1);
        @(negedge i_clk);
        chk("overrun_wr_addr", addra, wr_a);
        chk("overrun_wdata", $signed(wda), 1000);
        @(negedge i_clk);
        chk("overrun_valid_c5", ova, 1);
        repeat (8) @(negedge i_clk);
        chk("overrun_sticky", ovra, 1);
        chk("overrun_single_output", q_y.size(), 0);
        wr_a = (wr_a + 1) % 32000;

        // reset while the write is on the bus
        va = 1'b1; ena = 1'b1; lva = 3'd0; fba = 3'd0; mixa = 3'd0; da = 16'd777;
        @(negedge i_clk);
        va = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("pre_reset_we_n", wena, 0);
        rst_n = 1'b0;
        #1;
        chk("reset_we_n", wena, 1);
        chk("reset_addr", addra, 0);
        chk("reset_wdata", wda, 0);
        chk("reset_busy", busya, 0);
        chk("reset_valid", ova, 0);
        chk("reset_o_data", oda, 0);
        chk("reset_overrun", ovra, 0);
        repeat (2) @(negedge i_clk);
        chk("reset_no_valid", ova, 0);
        rst_n = 1'b1;
        wr_a = 0;
        @(negedge i_clk);
        send_a(mk(1, 0, 0, 0, 321, 0, 0, 321, 321));

        repeat (3) @(negedge i_clk);
        chk("queue_drained", q_y.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
